// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry path: key codes, display modes,
// scanner state encoding and the row/column to key-code map.
package keypad_entry_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam logic [5:0] BLANK_DIGIT = 6'd63;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_FLOW   = 2'b01;
  localparam logic [1:0] MODE_VIP    = 2'b10;
  localparam logic [1:0] MODE_STATIC = 2'b11;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2
  } scan_state_t;

  // Physical keypad layout: row 0 is the top row, column 0 the left column.
  function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_entry_scan.sv
// Keypad column scanner with tick-based press/release debounce; emits one
// key_valid pulse per debounced press.
module keypad_scan
  import keypad_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CNT + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;

  scan_state_t       state, state_n;
  logic [3:0]        col_n;
  logic [1:0]        lat_row, lat_row_n;
  logic [1:0]        lat_col, lat_col_n;
  logic [DEB_W-1:0]  deb_cnt, deb_n;
  logic              valid_n;
  logic [3:0]        code_n;
  logic [1:0]        low_row_c;
  logic [1:0]        col_idx_c;
  logic [3:0]        col_rot_c;

  assign tick_c = (tick_cnt == TICK_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    low_row_c = 2'd3;
    if (!row_in[0])      low_row_c = 2'd0;
    else if (!row_in[1]) low_row_c = 2'd1;
    else if (!row_in[2]) low_row_c = 2'd2;
  end

  always_comb begin
    col_idx_c = 2'd0;
    case (col_out)
      4'b1101: col_idx_c = 2'd1;
      4'b1011: col_idx_c = 2'd2;
      4'b0111: col_idx_c = 2'd3;
      default: col_idx_c = 2'd0;
    endcase
  end

  assign col_rot_c = {col_out[2:0], col_out[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      col_out   <= 4'b1110;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      deb_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      state     <= state_n;
      col_out   <= col_n;
      lat_row   <= lat_row_n;
      lat_col   <= lat_col_n;
      deb_cnt   <= deb_n;
      key_valid <= valid_n;
      key_code  <= code_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col_out;
    lat_row_n = lat_row;
    lat_col_n = lat_col;
    deb_n     = deb_cnt;
    valid_n   = 1'b0;
    code_n    = key_code;
    case (state)
      ST_SCAN: begin
        if (tick_c) begin
          if (row_in == 4'hF) begin
            col_n = col_rot_c;
          end else begin
            lat_row_n = low_row_c;
            lat_col_n = col_idx_c;
            deb_n     = '0;
            state_n   = ST_DEB_PRESS;
          end
        end
      end
      ST_DEB_PRESS: begin
        if (tick_c) begin
          if (!row_in[lat_row]) begin
            if (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
              deb_n   = '0;
              valid_n = 1'b1;
              code_n  = key_decode(lat_row, lat_col);
              state_n = ST_HELD;
            end else begin
              deb_n = deb_cnt + DEB_W'(1);
            end
          end else begin
            // Bounce: drop the candidate and carry on from the next column.
            deb_n   = '0;
            col_n   = col_rot_c;
            state_n = ST_SCAN;
          end
        end
      end
      ST_HELD: begin
        if (tick_c) begin
          if (row_in == 4'hF) begin
            if (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1)) begin
              deb_n   = '0;
              state_n = ST_SCAN;
            end else begin
              deb_n = deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_n = '0;
          end
        end
      end
      default: begin
        deb_n   = '0;
        state_n = ST_SCAN;
      end
    endcase
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: debounced key scanner feeding an 8-digit entry buffer,
// entry commit on '#', and the display mode register driven by A..D.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [5:0]  d7,
  output logic [5:0]  d6,
  output logic [5:0]  d5,
  output logic [5:0]  d4,
  output logic [5:0]  d3,
  output logic [5:0]  d2,
  output logic [5:0]  d1,
  output logic [5:0]  d0,
  output logic        entry_valid,
  output logic [31:0] entry_value,
  output logic [1:0]  mode
);

  logic [5:0]  dig [NUM_DIGITS];
  logic [3:0]  count;
  logic [31:0] entry_value_c;

  keypad_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // Blank positions read back as zero in the committed BCD value.
  always_comb begin
    entry_value_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      entry_value_c[4*i +: 4] = (dig[i] == BLANK_DIGIT) ? 4'd0 : dig[i][3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= BLANK_DIGIT;
      count       <= 4'd0;
      entry_valid <= 1'b0;
      entry_value <= '0;
      mode        <= MODE_OFF;
    end else begin
      entry_valid <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (count < 4'(NUM_DIGITS)) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) dig[i] <= dig[i-1];
            dig[0] <= {2'b00, key_code};
            count  <= count + 4'd1;
          end
        end else begin
          case (key_code)
            KEY_STAR: begin
              if (count != 4'd0) begin
                for (int i = 0; i < NUM_DIGITS - 1; i++) dig[i] <= dig[i+1];
                dig[NUM_DIGITS-1] <= BLANK_DIGIT;
                count <= count - 4'd1;
              end
            end
            KEY_HASH: begin
              if (count != 4'd0) begin
                entry_valid <= 1'b1;
                entry_value <= entry_value_c;
                for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= BLANK_DIGIT;
                count <= 4'd0;
              end
            end
            KEY_A:   mode <= MODE_FLOW;
            KEY_B:   mode <= MODE_VIP;
            KEY_C:   mode <= MODE_STATIC;
            KEY_D:   mode <= MODE_OFF;
            default: ;
          endcase
        end
      end
    end
  end

  assign d0 = dig[0];
  assign d1 = dig[1];
  assign d2 = dig[2];
  assign d3 = dig[3];
  assign d4 = dig[4];
  assign d5 = dig[5];
  assign d6 = dig[6];
  assign d7 = dig[7];

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a keypad matrix model, a vector table for
// the entry buffer and hand sequences for scan, bounce and reset corners.
module tb_keypad_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [5:0]  d7, d6, d5, d4, d3, d2, d1, d0;
  logic        entry_valid;
  logic [31:0] entry_value;
  logic [1:0]  mode;
  logic [47:0] d_all;

  int tests;
  int fails;
  int kv_count;

  logic       press_on;
  logic [1:0] press_r;
  logic [1:0] press_c;

  typedef struct {
    logic [3:0]  key;
    logic [47:0] exp_d;
    logic [1:0]  exp_mode;
    logic        exp_ev;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [20];

  keypad_entry #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .d7          (d7),
    .d6          (d6),
    .d5          (d5),
    .d4          (d4),
    .d3          (d3),
    .d2          (d2),
    .d1          (d1),
    .d0          (d0),
    .entry_valid (entry_valid),
    .entry_value (entry_value),
    .mode        (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d_all = {d7, d6, d5, d4, d3, d2, d1, d0};

  // Matrix model: a pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_in = 4'hF;
    if (press_on && !col_out[press_c]) row_in[press_r] = 1'b0;
  end

  always @(posedge clk) if (key_valid) kv_count <= kv_count + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Buffer image with n digits; digs holds them most-recent-in-lowest-nibble.
  function automatic logic [47:0] buf_of(input int n, input logic [31:0] digs);
    logic [47:0] r;
    for (int i = 0; i < 8; i++)
      r[6*i +: 6] = (i < n) ? {2'b00, digs[4*i +: 4]} : 6'd63;
    return r;
  endfunction

  task automatic set_key(input logic [3:0] code);
    case (code)
      4'd1:  begin press_r = 2'd0; press_c = 2'd0; end
      4'd2:  begin press_r = 2'd0; press_c = 2'd1; end
      4'd3:  begin press_r = 2'd0; press_c = 2'd2; end
      4'd10: begin press_r = 2'd0; press_c = 2'd3; end
      4'd4:  begin press_r = 2'd1; press_c = 2'd0; end
      4'd5:  begin press_r = 2'd1; press_c = 2'd1; end
      4'd6:  begin press_r = 2'd1; press_c = 2'd2; end
      4'd11: begin press_r = 2'd1; press_c = 2'd3; end
      4'd7:  begin press_r = 2'd2; press_c = 2'd0; end
      4'd8:  begin press_r = 2'd2; press_c = 2'd1; end
      4'd9:  begin press_r = 2'd2; press_c = 2'd2; end
      4'd12: begin press_r = 2'd2; press_c = 2'd3; end
      4'd14: begin press_r = 2'd3; press_c = 2'd0; end
      4'd0:  begin press_r = 2'd3; press_c = 2'd1; end
      4'd15: begin press_r = 2'd3; press_c = 2'd2; end
      default: begin press_r = 2'd3; press_c = 2'd3; end
    endcase
  endtask

  // Press and hold a key until key_valid (bounded); returns at the pulse cycle.
  task automatic press_and_wait(input logic [3:0] code, input string name);
    bit got;
    got = 1'b0;
    set_key(code);
    press_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (key_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_valid_seen"}, 64'(got), 64'd1);
    check({name, "_key_code"}, 64'(key_code), 64'(code));
  endtask

  initial begin
    logic [3:0] cols [4];
    int kv0;
    tests    = 0;
    fails    = 0;
    kv_count = 0;
    press_on = 1'b0;
    press_r  = 2'd0;
    press_c  = 2'd0;
    cols[0] = 4'b1110;
    cols[1] = 4'b1101;
    cols[2] = 4'b1011;
    cols[3] = 4'b0111;

    vecs[0]  = '{4'd14, buf_of(0, 32'h0),        2'b00, 1'b0, 32'h0};
    vecs[1]  = '{4'd14, buf_of(0, 32'h0),        2'b00, 1'b0, 32'h0};
    vecs[2]  = '{4'd15, buf_of(0, 32'h0),        2'b00, 1'b0, 32'h0};
    vecs[3]  = '{4'd1,  buf_of(1, 32'h1),        2'b00, 1'b0, 32'h0};
    vecs[4]  = '{4'd2,  buf_of(2, 32'h12),       2'b00, 1'b0, 32'h0};
    vecs[5]  = '{4'd3,  buf_of(3, 32'h123),      2'b00, 1'b0, 32'h0};
    vecs[6]  = '{4'd4,  buf_of(4, 32'h1234),     2'b00, 1'b0, 32'h0};
    vecs[7]  = '{4'd5,  buf_of(5, 32'h12345),    2'b00, 1'b0, 32'h0};
    vecs[8]  = '{4'd6,  buf_of(6, 32'h123456),   2'b00, 1'b0, 32'h0};
    vecs[9]  = '{4'd7,  buf_of(7, 32'h1234567),  2'b00, 1'b0, 32'h0};
    vecs[10] = '{4'd8,  buf_of(8, 32'h12345678), 2'b00, 1'b0, 32'h0};
    vecs[11] = '{4'd9,  buf_of(8, 32'h12345678), 2'b00, 1'b0, 32'h0};
    vecs[12] = '{4'd14, buf_of(7, 32'h1234567),  2'b00, 1'b0, 32'h0};
    vecs[13] = '{4'd15, buf_of(0, 32'h0),        2'b00, 1'b1, 32'h01234567};
    vecs[14] = '{4'd15, buf_of(0, 32'h0),        2'b00, 1'b0, 32'h01234567};
    vecs[15] = '{4'd10, buf_of(0, 32'h0),        2'b01, 1'b0, 32'h01234567};
    vecs[16] = '{4'd11, buf_of(0, 32'h0),        2'b10, 1'b0, 32'h01234567};
    vecs[17] = '{4'd12, buf_of(0, 32'h0),        2'b11, 1'b0, 32'h01234567};
    vecs[18] = '{4'd13, buf_of(0, 32'h0),        2'b00, 1'b0, 32'h01234567};
    vecs[19] = '{4'd0,  buf_of(1, 32'h0),        2'b00, 1'b0, 32'h01234567};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col_out", 64'(col_out), 64'(4'b1110));
    check("rst_key_valid", 64'(key_valid), 64'd0);
    check("rst_key_code", 64'(key_code), 64'd0);
    check("rst_digits", 64'(d_all), 64'(buf_of(0, 32'h0)));
    check("rst_entry_valid", 64'(entry_valid), 64'd0);
    check("rst_entry_value", 64'(entry_value), 64'd0);
    check("rst_mode", 64'(mode), 64'd0);
    rst = 1'b0;

    // Idle rotation: one column step every 4 clocks, 16 ticks
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k % 4 == 0) check($sformatf("idle_col_k%0d", k), 64'(col_out), 64'(cols[(k / 4) % 4]));
    end
    check("idle_no_key_valid", 64'(kv_count), 64'd0);

    // Key '5'; re-press within the release window stays in HELD, no repeat
    kv0 = kv_count;
    press_and_wait(4'd5, "k5");
    @(negedge clk);
    check("k5_pulse_one_cycle", 64'(key_valid), 64'd0);
    check("k5_digits", 64'(d_all), 64'(buf_of(1, 32'h5)));
    press_on = 1'b0;
    repeat (8) @(negedge clk);
    press_on = 1'b1;
    repeat (16) @(negedge clk);
    press_on = 1'b0;
    repeat (24) @(negedge clk);
    check("k5_single_pulse", 64'(kv_count - kv0), 64'd1);

    // Bounce during DEB_PRESS on key '7' must not report
    kv0 = kv_count;
    set_key(4'd7);
    for (int b = 0; b < 3; b++) begin
      press_on = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (row_in != 4'hF) break;
        @(negedge clk);
      end
      repeat (8) @(negedge clk);
      press_on = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("bounce_no_pulse", 64'(kv_count - kv0), 64'd0);
    kv0 = kv_count;
    press_and_wait(4'd7, "k7_stable");
    @(negedge clk);
    check("k7_digits", 64'(d_all), 64'(buf_of(2, 32'h57)));
    check("k7_single_pulse", 64'(kv_count - kv0), 64'd1);
    repeat (8) @(negedge clk);

    // Reset while HELD: outputs clear, the still-held key needs a new debounce
    rst = 1'b1;
    @(negedge clk);
    check("rsth_col_out", 64'(col_out), 64'(4'b1110));
    check("rsth_key_valid", 64'(key_valid), 64'd0);
    check("rsth_key_code", 64'(key_code), 64'd0);
    check("rsth_digits", 64'(d_all), 64'(buf_of(0, 32'h0)));
    check("rsth_mode", 64'(mode), 64'd0);
    check("rsth_entry_value", 64'(entry_value), 64'd0);
    rst = 1'b0;
    kv0 = kv_count;
    repeat (12) @(negedge clk);
    check("rsth_no_early_pulse", 64'(kv_count - kv0), 64'd0);
    press_and_wait(4'd7, "rsth_redebounce");
    @(negedge clk);
    check("rsth_digits_after", 64'(d_all), 64'(buf_of(1, 32'h7)));
    press_on = 1'b0;
    repeat (24) @(negedge clk);

    // Entry buffer vector table
    for (int v = 0; v < 20; v++) begin
      kv0 = kv_count;
      press_and_wait(vecs[v].key, $sformatf("v%0d", v));
      @(negedge clk);
      check($sformatf("v%0d_pulse_one_cycle", v), 64'(key_valid), 64'd0);
      check($sformatf("v%0d_entry_valid", v), 64'(entry_valid), 64'(vecs[v].exp_ev));
      check($sformatf("v%0d_digits", v), 64'(d_all), 64'(vecs[v].exp_d));
      check($sformatf("v%0d_mode", v), 64'(mode), 64'(vecs[v].exp_mode));
      check($sformatf("v%0d_entry_value", v), 64'(entry_value), 64'(vecs[v].exp_val));
      repeat (8) @(negedge clk);
      press_on = 1'b0;
      repeat (24) @(negedge clk);
      check($sformatf("v%0d_single_pulse", v), 64'(kv_count - kv0), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the 8-digit seven-segment display path: scans a 4x4 active-low matrix keypad, debounces presses and decodes them into key codes.
- Collects decimal digits into an 8-digit entry buffer whose 6-bit-per-digit outputs feed the display's static digit inputs.
- Also produces the 2-bit display mode select.
- Sits between the board keypad pins and the display/control logic.

Parameters:
- SCAN_DIV, 100000, clk cycles per column dwell ("tick" period; 1 ms at 100 MHz).
- DEBOUNCE_CNT, 20, consecutive ticks of stable rows required for both press and release.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- row_in  input  4  keypad rows, active-low, pre-synchronised externally (2-FF)
- col_out  output  4  column drive, active-low, exactly one bit low
- key_valid  output  1  one-cycle pulse, debounced new press
- key_code  output  4  code of last pressed key, held until next press
- d7..d0  output  6 each  entry buffer digits, d0 = most recent; 6'd63 = blank
- entry_valid  output  1  one-cycle pulse on accepted '#'
- entry_value  output  32  8 BCD nibbles of the last entry (blank -> 0), held
- mode  output  2  display mode select

Behaviour:
- Reset values:
  - col_out=4'b1110, key_valid=0, key_code=0, d7..d0=63, entry count=0.
  - entry_valid=0, entry_value=0, mode=2'b00, FSM=SCAN, tick and debounce counters=0.
  - Reset mid-press returns to SCAN; the press is not reported.
- Tick: a counter pulses when it reaches SCAN_DIV-1, then wraps to 0. All FSM sampling occurs on tick cycles only.
- Key map (row r, col c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *,0,#,D
  - Codes: digits = value, A=10, B=11, C=12, D=13, *=14, #=15.
- FSM states:
  - SCAN: on a tick with row_in==4'hF, rotate col_out (1110->1101->1011->0111->1110). On a tick with any row low, latch col and the lowest-index low row, then go to DEB_PRESS with col_out held.
  - DEB_PRESS: on each tick, if the latched row is still low, increment the counter. When it reaches DEBOUNCE_CNT, go to HELD and pulse key_valid in the next cycle with key_code updated. If the latched row is high, clear the counter, go to SCAN and resume rotation from the next column.
  - HELD: no repeat. Count consecutive ticks with row_in==4'hF; any low row clears the count. At DEBOUNCE_CNT, go to SCAN.
- Buffer actions, applied the cycle after key_valid (T+1):
  - digit: if count<8, shift d7<=d6..d1<=d0, d0<=digit, count+1. If count==8, ignore.
  - '*': if count>0, backspace: d0<=d1..d6<=d7, d7<=63, count-1. Otherwise no-op.
  - '#': if count>0, pulse entry_valid at T+1, load entry_value, set all d=63 and count=0 at T+1. If count==0, no-op with no pulse.
  - A/B/C/D: set mode to 01/10/11/00 respectively at T+1. Buffer unchanged.
- entry_value: nibble i = d_i[3:0] if d_i != 63, else 0.
- Simultaneous keys: lowest row in the first scanned column wins. Other keys are ignored until full release.

Decomposition:
- Shared package:
  - key code constants (KEY_A..KEY_D, KEY_STAR=14, KEY_HASH=15)
  - BLANK_DIGIT=6'd63
  - mode encodings (MODE_OFF=00, MODE_FLOW=01, MODE_VIP=10, MODE_STATIC=11)
  - FSM state enum
- Sub-module keypad_scan: tick counter, column rotation, debounce FSM, key decode. Outputs key_valid/key_code.
- The top holds the entry buffer and mode register.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset, then idle rows=F for 16 ticks -> col_out cycles 1110,1101,1011,0111,1110; key_valid never asserted.
- Press '5' (row1 low while col1 driven) for 3 ticks, then release for 3 ticks -> a single key_valid with key_code=5; d0=5, d1..d7=63; HELD exits only after the 3 released ticks.
- Row bounce low/high/low during DEB_PRESS -> no key_valid; after a 3-tick stable press, exactly one pulse.
- Enter 1,2,3,4,5,6,7,8,9 -> d7..d0=1..8, the 9 is ignored; '*' -> d7=63, d0=7; '#' -> entry_valid pulse, entry_value=32'h01234567, all d=63.
- '#' with empty buffer -> no entry_valid; keys A, C, D -> mode 01, 11, 00; buffer unchanged.
- Assert rst during HELD -> next cycle all outputs at reset values, col_out=1110, no key_valid after rst deasserts while the key is still held until a new debounce completes.
